// File: rtl/ladner_fischer_adder.sv
// Registered WIDTH-bit adder whose carries come from a Ladner-Fischer
// parallel-prefix network of radix VALENCY (2 or 4); one cycle of latency.
module ladner_fischer_adder #(
   parameter int WIDTH   = 128,
   parameter int VALENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH:1]   A,
   input  logic [WIDTH:1]   B,
   input  logic             Cin,
   output logic [WIDTH:1]   S,
   output logic             Cout
);

   // Smallest number of radix-v levels whose span covers n prefix positions.
   function automatic int calc_levels(input int n, input int v);
      int  lvl;
      int  span;
      lvl  = 0;
      span = 1;
      while (span < n) begin
         span = span * v;
         lvl  = lvl + 1;
      end
      return lvl;
   endfunction

   localparam int NPOS   = WIDTH + 1;
   localparam int LEVELS = calc_levels(NPOS, VALENCY);
   localparam int NPAD   = VALENCY ** LEVELS;

   if (VALENCY != 2 && VALENCY != 4) begin : g_bad_valency
      $error("ladner_fischer_adder: VALENCY must be 2 or 4");
   end

   if (WIDTH < 2 || WIDTH > 256) begin : g_bad_width
      $error("ladner_fischer_adder: WIDTH must be in 2..256");
   end

   logic [WIDTH:1] s_d;
   logic [WIDTH:1] s_q;
   logic           cout_d;
   logic           cout_q;

   for (genvar k = 0; k <= LEVELS; k++) begin : g_level
      logic [NPAD-1:0] g;
      logic [NPAD-1:0] p;

      if (k == 0) begin : g_pre
         always_comb begin
            g    = '0;
            p    = '0;
            g[0] = Cin;
            for (int i = 1; i <= WIDTH; i++) begin
               g[i] = A[i] & B[i];
               p[i] = A[i] ^ B[i];
            end
         end
      end else begin : g_tree
         localparam int SUB = VALENCY ** (k - 1);

         // Each position in sub-block s of a VALENCY^k block absorbs the last
         // prefix of every lower sub-block, nearest first, in a single cell.
         always_comb begin
            g = g_level[k-1].g;
            p = g_level[k-1].p;
            for (int pos = 0; pos < NPAD; pos++) begin
               int sub_idx;
               int base;
               sub_idx = (pos / SUB) % VALENCY;
               base    = pos - (pos % (SUB * VALENCY));
               for (int t = VALENCY - 2; t >= 0; t--) begin
                  if (t < sub_idx) begin
                     g[pos] = g[pos] | (p[pos] & g_level[k-1].g[base + (t + 1) * SUB - 1]);
                     p[pos] = p[pos] & g_level[k-1].p[base + (t + 1) * SUB - 1];
                  end
               end
            end
         end
      end
   end

   // Final-level G at position i is the carry out of bit i (Cin sits at 0).
   always_comb begin
      s_d    = '0;
      cout_d = g_level[LEVELS].g[WIDTH];
      for (int i = 1; i <= WIDTH; i++) begin
         s_d[i] = g_level[0].p[i] ^ g_level[LEVELS].g[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign S    = s_q;
   assign Cout = cout_q;

endmodule

// File: tb/tb_ladner_fischer_adder.sv
// Bench for ladner_fischer_adder: ten width/valency configurations run in
// lockstep and are checked against a plain-arithmetic model of A+B+Cin.
module tb_ladner_fischer_adder;

   localparam int NCFG = 10;
   localparam int MAIN = 8;

   function automatic int cfg_width(input int idx);
      case (idx / 2)
         0:       return 8;
         1:       return 16;
         2:       return 33;
         3:       return 64;
         default: return 128;
      endcase
   endfunction

   function automatic int cfg_valency(input int idx);
      return ((idx % 2) == 1) ? 4 : 2;
   endfunction

   logic         clk;
   logic         rst;
   logic [127:0] a_in;
   logic [127:0] b_in;
   logic         cin;
   logic [128:0] res [NCFG];

   int vec_count;
   int miscompares;

   for (genvar ci = 0; ci < NCFG; ci++) begin : g_dut
      localparam int W = cfg_width(ci);
      localparam int V = cfg_valency(ci);
      logic [W:1] s_o;
      logic       c_o;

      ladner_fischer_adder #(.WIDTH(W), .VALENCY(V)) u_dut (
         .clk  (clk),
         .rst  (rst),
         .A    (a_in[W-1:0]),
         .B    (b_in[W-1:0]),
         .Cin  (cin),
         .S    (s_o),
         .Cout (c_o)
      );

      assign res[ci] = 129'({c_o, s_o});
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Exact (WIDTH+1)-bit sum of the operands truncated to the config width.
   function automatic logic [128:0] model_sum(input int idx, input logic [127:0] a,
                                              input logic [127:0] b, input logic c);
      logic [128:0] mask;
      logic [128:0] ma;
      logic [128:0] mb;
      mask = (129'd1 << cfg_width(idx)) - 129'd1;
      ma   = {1'b0, a} & mask;
      mb   = {1'b0, b} & mask;
      return ma + mb + {128'd0, c};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic drive_edge(input logic [127:0] a, input logic [127:0] b,
                             input logic c, input logic r);
      @(negedge clk);
      a_in = a;
      b_in = b;
      cin  = c;
      rst  = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [127:0] a;
      logic [127:0] b;
      a = rand128();
      b = rand128();
      drive_edge(a, b, 1'b1, 1'b1);
      for (int c = 0; c < NCFG; c++) begin
         vec_count++;
         if (res[c] !== 129'd0) begin
            miscompares++;
            $display("[TB] FAIL reset cfg%0d: got %h expected 0", c, res[c]);
         end
      end
   endtask

   task automatic test_directed();
      logic [127:0] da [5];
      logic [127:0] db [5];
      logic         dc [5];
      logic [128:0] dk [5];
      logic [128:0] exp_v;
      da[0] = 128'd10000;  db[0] = 128'd5000;   dc[0] = 1'b0; dk[0] = 129'd15000;
      da[1] = 128'hFFFF;   db[1] = 128'd0;      dc[1] = 1'b1; dk[1] = 129'h1_0000;
      da[2] = 128'd10000;  db[2] = 128'd55000;  dc[2] = 1'b1; dk[2] = 129'd65001;
      da[3] = '1;          db[3] = 128'd0;      dc[3] = 1'b1; dk[3] = {1'b1, 128'd0};
      da[4] = '1;          db[4] = '1;          dc[4] = 1'b1; dk[4] = {1'b1, {128{1'b1}}};
      for (int v = 0; v < 5; v++) begin
         drive_edge(da[v], db[v], dc[v], 1'b0);
         vec_count++;
         if (res[MAIN] !== dk[v]) begin
            miscompares++;
            $display("[TB] FAIL directed%0d main: got %h expected %h", v, res[MAIN], dk[v]);
         end
         for (int c = 0; c < NCFG; c++) begin
            exp_v = model_sum(c, da[v], db[v], dc[v]);
            vec_count++;
            if (res[c] !== exp_v) begin
               miscompares++;
               $display("[TB] FAIL directed%0d cfg%0d: got %h expected %h", v, c, res[c], exp_v);
            end
         end
      end
      drive_edge(128'd0, 128'd0, 1'b0, 1'b0);
      for (int c = 0; c < NCFG; c++) begin
         vec_count++;
         if (res[c] !== 129'd0) begin
            miscompares++;
            $display("[TB] FAIL zero cfg%0d: got %h expected 0", c, res[c]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      drive_edge(128'd10000, 128'd5000, 1'b0, 1'b0);
      drive_edge(128'd10000, 128'd5000, 1'b0, 1'b1);
      for (int c = 0; c < NCFG; c++) begin
         vec_count++;
         if (res[c] !== 129'd0) begin
            miscompares++;
            $display("[TB] FAIL midreset cfg%0d: got %h expected 0", c, res[c]);
         end
      end
      drive_edge(128'd10000, 128'd5000, 1'b0, 1'b0);
      vec_count++;
      if (res[MAIN] !== 129'd15000) begin
         miscompares++;
         $display("[TB] FAIL postreset main: got %h expected %h", res[MAIN], 129'd15000);
      end
   endtask

   task automatic test_random(input int n);
      logic [127:0] a;
      logic [127:0] b;
      logic         c_in;
      logic [128:0] exp_v;
      for (int i = 0; i < n; i++) begin
         a    = rand128();
         b    = rand128();
         c_in = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0:       b = ~a;
            1:       a = '1;
            default: ;
         endcase
         drive_edge(a, b, c_in, 1'b0);
         for (int c = 0; c < NCFG; c++) begin
            exp_v = model_sum(c, a, b, c_in);
            vec_count++;
            if (res[c] !== exp_v) begin
               miscompares++;
               $display("[TB] FAIL random%0d cfg%0d: got %h expected %h", i, c, res[c], exp_v);
            end
         end
      end
   endtask

   initial begin
      vec_count   = 0;
      miscompares = 0;
      rst  = 1'b1;
      a_in = '0;
      b_in = '0;
      cin  = 1'b0;
      test_reset();
      test_directed();
      test_reset_midstream();
      test_random(10000);
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
